adder_operand_fifo: RTL

//  Upstream feeder for the combinational N-bit ripple adder. Buffers operand

---
 rtl/adder_operand_fifo_if.sv | 32 +++
 rtl/adder_operand_fifo.sv | 111 +++++++++++
 2 files changed

// File: rtl/adder_operand_fifo_if.sv
// Operand-pair stream bundle between a producer, the operand FIFO and the adder.
// Latency: none (wires only).
// Backpressure: IN_READY throttles the producer; OUT_READY throttles the FIFO.
// Ports: FLUSH/IN_* from producer, OUT_* to consumer, LEVEL/PAIR_CNT status.
interface adder_operand_fifo_if #(
    parameter int N     = 4,
    parameter int DEPTH = 4
);
    logic                     FLUSH;
    logic                     IN_VALID;
    logic                     IN_READY;
    logic [N-1:0]             IN_A;
    logic [N-1:0]             IN_B;
    logic                     OUT_VALID;
    logic                     OUT_READY;
    logic [N-1:0]             OUT_A;
    logic [N-1:0]             OUT_B;
    logic [$clog2(DEPTH):0]   LEVEL;
    logic [15:0]              PAIR_CNT;

    // FIFO side
    modport slave (
        input  FLUSH, IN_VALID, IN_A, IN_B, OUT_READY,
        output IN_READY, OUT_VALID, OUT_A, OUT_B, LEVEL, PAIR_CNT
    );

    // Producer/consumer side
    modport master (
        output FLUSH, IN_VALID, IN_A, IN_B, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_A, OUT_B, LEVEL, PAIR_CNT
    );
endinterface

// File: rtl/adder_operand_fifo.sv
// Operand-pair FIFO feeding the ripple adder's A/B inputs from registered outputs.
// Latency: 1 cycle from push into empty to OUT_VALID; 1 pair/cycle sustained.
// Backpressure: IN_READY = LEVEL != DEPTH (registered decode); outputs hold while stalled.
// Ports: clk, rst_n (async active-low); bus.slave carries FLUSH, IN_*, OUT_*, LEVEL, PAIR_CNT.
module adder_operand_fifo #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_operand_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Storage holds every pair in flight, including the one mirrored on OUT_*.
    logic [N-1:0]  r_mem_a [DEPTH];
    logic [N-1:0]  r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_out_vld;
    logic [N-1:0]  r_out_a;
    logic [N-1:0]  r_out_b;
    logic [15:0]   r_pair_cnt;

    logic          w_in_rdy;
    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;
    logic [AW-1:0] w_rd_ptr_inc;
    logic          w_load;
    logic [N-1:0]  w_load_a;
    logic [N-1:0]  w_load_b;

    assign w_in_rdy     = (r_level != LW'(DEPTH));
    assign w_push       = bus.IN_VALID & w_in_rdy;
    assign w_pop        = r_out_vld & bus.OUT_READY;
    assign w_level_nxt  = r_level + LW'(w_push) - LW'(w_pop);
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

    // Decide what the output register shows next. Bypass the input only when
    // the incoming pair becomes the oldest (empty, or last pair leaving);
    // otherwise the next-oldest pair is already in storage.
    always_comb begin
        w_load   = 1'b0;
        w_load_a = r_mem_a[w_rd_ptr_inc];
        w_load_b = r_mem_b[w_rd_ptr_inc];
        if (w_pop) begin
            if (r_level >= LW'(2)) begin
                w_load = 1'b1;
            end else if (w_push) begin
                w_load   = 1'b1;
                w_load_a = bus.IN_A;
                w_load_b = bus.IN_B;
            end
        end else if ((r_level == '0) && w_push) begin
            w_load   = 1'b1;
            w_load_a = bus.IN_A;
            w_load_b = bus.IN_B;
        end
    end

    // Storage needs no reset: LEVEL alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push && !bus.FLUSH) begin
            r_mem_a[r_wr_ptr] <= bus.IN_A;
            r_mem_b[r_wr_ptr] <= bus.IN_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_vld  <= 1'b0;
            r_out_a    <= '0;
            r_out_b    <= '0;
            r_pair_cnt <= '0;
        end else if (bus.FLUSH) begin
            // Same-cycle push/pop are dropped; OUT_A/OUT_B keep stale data.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_vld  <= 1'b0;
            r_pair_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= w_rd_ptr_inc;
                r_pair_cnt <= r_pair_cnt + 16'd1;
            end
            if (w_load) begin
                r_out_a <= w_load_a;
                r_out_b <= w_load_b;
            end
            r_level   <= w_level_nxt;
            r_out_vld <= (w_level_nxt != '0);
        end
    end

    assign bus.IN_READY  = w_in_rdy;
    assign bus.OUT_VALID = r_out_vld;
    assign bus.OUT_A     = r_out_a;
    assign bus.OUT_B     = r_out_b;
    assign bus.LEVEL     = r_level;
    assign bus.PAIR_CNT  = r_pair_cnt;
endmodule
